// File: rtl/wb_ctrl.sv
// Writeback controller in front of the register file's single write port.
// Merges single-cycle ALU results and multi-cycle data-memory loads into one
// registered write stream. It also drives the data-memory read handshake and
// raises stall for hazards that upstream must resolve by holding.
module wb_ctrl #(
    parameter int pw      = 4,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          alu_wr_en,
    input  logic [pw:0]   alu_dst,
    input  logic [7:0]    alu_data,
    input  logic          ld_req,
    input  logic [pw:0]   ld_dst,
    input  logic [7:0]    ld_addr,
    input  logic [pw:0]   rd_addrOpr,
    input  logic          reads_acc,
    output logic          mem_rd_en,
    output logic [7:0]    mem_rd_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          wr_en,
    output logic [pw:0]   wr_addr,
    output logic [7:0]    data_in,
    output logic          ld_busy,
    output logic          stall
);

    // The counter must be able to hold MEM_LAT itself.
    localparam int CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [pw:0]     r_pend_dst;
    logic            r_mem_rd_en;
    logic [7:0]      r_mem_rd_addr;
    logic            r_wr_en;
    logic [pw:0]     r_wr_addr;
    logic [7:0]      r_data_in;

    logic            w_capture;
    logic            w_stall;
    logic            w_alu_ok;
    logic            w_ld_ok;

    // Hazard detection: the capture cycle owns the write port, and while a load
    // is pending any dependence on its destination or a second load must wait.
    always_comb begin
        w_capture = 1'b0;
        w_stall   = 1'b0;
        if (r_state == ST_WAIT) begin
            w_capture = (r_cnt == {CW{1'b0}});
            w_stall   = w_capture
                      | ((rd_addrOpr == r_pend_dst) && (rd_addrOpr != {(pw+1){1'b0}}))
                      | (reads_acc && (r_pend_dst == {(pw+1){1'b0}}))
                      | (alu_wr_en && (alu_dst == r_pend_dst))
                      | ld_req;
        end else begin
            w_capture = 1'b0;
            w_stall   = 1'b0;
        end
    end

    // Requests are only honoured when upstream is not being held.
    always_comb begin
        w_alu_ok = alu_wr_en & ~w_stall;
        w_ld_ok  = ld_req & ~w_stall & (r_state == ST_IDLE);
    end

    // Load FSM, memory read strobe and the merged registered write stream.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= {CW{1'b0}};
            r_pend_dst    <= {(pw+1){1'b0}};
            r_mem_rd_en   <= 1'b0;
            r_mem_rd_addr <= 8'h00;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= {(pw+1){1'b0}};
            r_data_in     <= 8'h00;
        end else begin
            // The read strobe is a one-cycle pulse unless a load issues now.
            r_mem_rd_en <= 1'b0;

            // Write port: a capturing load wins (ALU is stalled that cycle).
            if (w_capture) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_pend_dst;
                r_data_in <= mem_rd_data;
            end else if (w_alu_ok) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= alu_dst;
                r_data_in <= alu_data;
            end else begin
                r_wr_en   <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_ld_ok) begin
                        r_state       <= ST_WAIT;
                        r_cnt         <= CW'(MEM_LAT);
                        r_pend_dst    <= ld_dst;
                        r_mem_rd_addr <= ld_addr;
                        r_mem_rd_en   <= 1'b1;
                    end else begin
                        r_state       <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (w_capture) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt   <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign mem_rd_en   = r_mem_rd_en;
    assign mem_rd_addr = r_mem_rd_addr;
    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign data_in     = r_data_in;
    assign ld_busy     = (r_state == ST_WAIT);
    assign stall       = w_stall;

endmodule

// File: tb/tb_wb_ctrl.sv
// Self-checking bench for wb_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-count based behavioural model.
module tb_wb_ctrl;

    localparam int PW = 4;
    localparam int ML = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          alu_wr_en;
    logic [PW:0]   alu_dst;
    logic [7:0]    alu_data;
    logic          ld_req;
    logic [PW:0]   ld_dst;
    logic [7:0]    ld_addr;
    logic [PW:0]   rd_addrOpr;
    logic          reads_acc;
    logic          mem_rd_en;
    logic [7:0]    mem_rd_addr;
    logic [7:0]    mem_rd_data;
    logic          wr_en;
    logic [PW:0]   wr_addr;
    logic [7:0]    data_in;
    logic          ld_busy;
    logic          stall;

    wb_ctrl #(.pw(PW), .MEM_LAT(ML)) dut (
        .clk(clk), .reset_n(reset_n),
        .alu_wr_en(alu_wr_en), .alu_dst(alu_dst), .alu_data(alu_data),
        .ld_req(ld_req), .ld_dst(ld_dst), .ld_addr(ld_addr),
        .rd_addrOpr(rd_addrOpr), .reads_acc(reads_acc),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .data_in(data_in),
        .ld_busy(ld_busy), .stall(stall)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: a load is described by how many cycles ago its read strobe
    // fired (k). It is busy for k = 0..ML and captures data at k == ML.
    logic [7:0]  mem [256];
    bit          m_busy;
    int          m_k;
    logic [PW:0] m_dst;
    logic [7:0]  m_addr;
    logic        e_wr_en;
    logic [PW:0] e_wr_addr;
    logic [7:0]  e_data_in;
    logic [7:0]  e_rd_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy    = 1'b0;
        m_k       = 0;
        m_dst     = '0;
        m_addr    = 8'h00;
        e_wr_en   = 1'b0;
        e_wr_addr = '0;
        e_data_in = 8'h00;
        e_rd_addr = 8'h00;
    endtask

    // One clock cycle: drive inputs, check all outputs, advance the model.
    task automatic step(input logic rn, input logic a_en, input logic [PW:0] a_dst,
                        input logic [7:0] a_data, input logic l_req, input logic [PW:0] l_dst,
                        input logic [7:0] l_addr, input logic [PW:0] opr, input logic acc);
        bit e_stall;
        bit cap;
        bit was_busy;
        reset_n    = rn;
        alu_wr_en  = a_en;
        alu_dst    = a_dst;
        alu_data   = a_data;
        ld_req     = l_req;
        ld_dst     = l_dst;
        ld_addr    = l_addr;
        rd_addrOpr = opr;
        reads_acc  = acc;
        cap = m_busy && (m_k == ML);
        // Memory answers exactly ML cycles after the strobe, garbage otherwise.
        mem_rd_data = cap ? mem[m_addr] : 8'($urandom);
        #1;
        e_stall = m_busy && (cap || (opr == m_dst && opr != 0) || (acc && m_dst == 0)
                             || (a_en && a_dst == m_dst) || l_req);
        check("stall",       32'(stall),       32'(e_stall));
        check("ld_busy",     32'(ld_busy),     32'(m_busy));
        check("mem_rd_en",   32'(mem_rd_en),   32'(m_busy && m_k == 0));
        check("mem_rd_addr", 32'(mem_rd_addr), 32'(e_rd_addr));
        check("wr_en",       32'(wr_en),       32'(e_wr_en));
        check("wr_addr",     32'(wr_addr),     32'(e_wr_addr));
        check("data_in",     32'(data_in),     32'(e_data_in));
        @(posedge clk);
        if (!rn) begin
            model_reset();
        end else begin
            was_busy = m_busy;
            if (cap) begin
                e_wr_en = 1'b1; e_wr_addr = m_dst; e_data_in = mem[m_addr];
                m_busy  = 1'b0;
            end else if (a_en && !e_stall) begin
                e_wr_en = 1'b1; e_wr_addr = a_dst; e_data_in = a_data;
            end else begin
                e_wr_en = 1'b0;
            end
            if (m_busy) m_k++;
            if (!was_busy && l_req) begin
                m_busy = 1'b1; m_k = 0; m_dst = l_dst; m_addr = l_addr; e_rd_addr = l_addr;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00, 5'd0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h20] = 8'hC3;
        reset_n = 1'b0; alu_wr_en = 1'b0; alu_dst = '0; alu_data = 8'h00;
        ld_req = 1'b0; ld_dst = '0; ld_addr = 8'h00; rd_addrOpr = '0; reads_acc = 1'b0;
        mem_rd_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // ALU write to R3.
        step(1'b1, 1'b1, 5'd3, 8'h5A, 1'b0, 5'd0, 8'h00, 5'd0, 1'b0);
        idle(2);
        // Load R5 from 0x20 with operand hazards during the wait.
        step(1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 5'd5, 8'h20, 5'd0, 1'b0);
        step(1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00, 5'd5, 1'b0);
        step(1'b1, 1'b1, 5'd5, 8'h77, 1'b0, 5'd0, 8'h00, 5'd0, 1'b0);
        idle(3);
        // Load to R0 with an accumulator read in the first wait cycle.
        step(1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 5'd0, 8'h20, 5'd0, 1'b0);
        step(1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00, 5'd0, 1'b1);
        idle(3);
        // Back-to-back loads, second request held until accepted.
        step(1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 5'd5, 8'h20, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 5'd6, 8'h31, 5'd0, 1'b0);
        idle(4);
        // Same-cycle ALU and load to R5; MSB address passes through.
        step(1'b1, 1'b1, 5'd5, 8'h11, 1'b1, 5'd5, 8'h20, 5'd0, 1'b0);
        idle(4);
        step(1'b1, 1'b1, 5'd19, 8'hE1, 1'b0, 5'd0, 8'h00, 5'd0, 1'b0);
        // Reset in the middle of a load drops it.
        step(1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 5'd7, 8'h20, 5'd0, 1'b0);
        idle(1);
        step(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00, 5'd0, 1'b0);
        idle(3);

        // Random traffic with small register numbers to provoke hazards.
        for (int c = 0; c < 3000; c++) begin
            logic [PW:0] d1, d2, op;
            d1 = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            d2 = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            op = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 1) == 1), d1, 8'($urandom),
                 ($urandom_range(0, 2) == 0), d2, 8'($urandom),
                 op, ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_ctrl.md
Name: wb_ctrl

Overview:
- Writeback controller sitting directly upstream of the register file's single write port.
- Merges single-cycle ALU results with multi-cycle data-memory loads into one registered write stream: wr_en, wr_addr, data_in.
- Owns the data-memory read handshake for loads.
- Raises stall for load-use hazards, write-after-write hazards, port conflicts and back-to-back loads.

Parameters:
- pw, 4: register address pointer width; register addresses are pw+1 bits wide, matching the register file write port.
- MEM_LAT, 2: data-memory read latency in cycles. mem_rd_data is valid MEM_LAT cycles after the mem_rd_en cycle. Legal range is 1 or greater.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset.
- alu_wr_en  in  1  ALU result writeback request this cycle.
- alu_dst  in  pw+1  ALU destination register.
- alu_data  in  8  ALU result.
- ld_req  in  1  load issue request.
- ld_dst  in  pw+1  load destination register.
- ld_addr  in  8  data-memory byte address.
- rd_addrOpr  in  pw+1  operand register read by the current instruction.
- reads_acc  in  1  current instruction reads the accumulator (R0).
- mem_rd_en  out  1  data-memory read strobe; registered.
- mem_rd_addr  out  8  data-memory read address; registered.
- mem_rd_data  in  8  data-memory read data.
- wr_en  out  1  register-file write enable; registered.
- wr_addr  out  pw+1  register-file write address; registered.
- data_in  out  8  register-file write data; registered.
- ld_busy  out  1  load in flight (state != IDLE).
- stall  out  1  upstream must hold the current instruction; combinational.

Behaviour:
- Reset: when reset_n=0 at posedge:
  - state<=IDLE, cnt<=0, pend_dst<=0.
  - wr_en, wr_addr, data_in, mem_rd_en, mem_rd_addr all <=0.
  - Any in-flight load is dropped; its mem_rd_data is never written.
- States:
  - IDLE: no load pending.
  - WAIT: load issued, counting latency.
- IDLE -> WAIT: on ld_req=1 with stall=0.
  - pend_dst<=ld_dst, mem_rd_addr<=ld_addr, mem_rd_en<=1, cnt<=MEM_LAT.
  - mem_rd_en is high for exactly one cycle (the first WAIT cycle), then 0.
- WAIT:
  - cnt decrements each cycle.
  - Capture cycle = WAIT with cnt==0. Sample mem_rd_data; wr_en<=1, wr_addr<=pend_dst, data_in<=mem_rd_data; state<=IDLE.
  - Load write is visible MEM_LAT+1 cycles after mem_rd_en.
- ALU path: alu_wr_en=1 and stall=0 -> next cycle wr_en=1, wr_addr=alu_dst, data_in=alu_data. Latency 1.
- No write this cycle -> wr_en<=0; wr_addr and data_in hold their last value.
- Inputs are ignored while stall=1; upstream re-presents them.
- stall=1 if any of the following hold:
  - (a) capture cycle: reserves the write port for the load.
  - (b) state=WAIT and rd_addrOpr==pend_dst and rd_addrOpr!=0. R0 operand reads return 0 in the register file, so they carry no hazard.
  - (c) state=WAIT and reads_acc=1 and pend_dst==0.
  - (d) state=WAIT and alu_wr_en=1 and alu_dst==pend_dst (WAW).
  - (e) state=WAIT and ld_req=1 (only one load outstanding).
- In IDLE, stall=0 always.
- Simultaneous ALU write and ld_req in IDLE with stall=0: both accepted.
  - ALU write appears next cycle.
  - Load write appears later, so for equal destinations the load value is final.
- Address MSB (bit pw) is passed through unmodified; the block does no range check.
- ld_busy = (state==WAIT), so it is also 0 during and after reset.

Test Plan (MEM_LAT=2, pw=4; cycle 0 = first cycle after reset release):
- ALU write: alu_wr_en=1, alu_dst=3, alu_data=0x5A in c0 -> c1 wr_en=1, wr_addr=3, data_in=0x5A; c2 wr_en=0; stall=0 throughout.
- Load: ld_req=1, ld_dst=5, ld_addr=0x20 in c0 -> mem_rd_en=1 and mem_rd_addr=0x20 in c1 only; ld_busy=1 in c1..c3; memory drives 0xC3 in c3; stall=1 in c3; c4 wr_en=1, wr_addr=5, data_in=0xC3.
- Hazards during load to R5 (c1..c2):
  - rd_addrOpr=5 -> stall=1.
  - rd_addrOpr=0 -> stall=0.
  - alu_wr_en=1 with alu_dst=5 -> stall=1 and no write in next cycle.
  - Load to R0 with reads_acc=1 in c1 -> stall=1.
- Back-to-back loads: second ld_req held from c1 -> stall=1 in c1..c3; accepted c4; mem_rd_en=1 in c5.
- Same-cycle ALU+load in c0: alu_dst=5 with 0x11, ld_dst=5 -> c1 writes R5=0x11; c4 writes R5=0xC3.
- Reset mid-load: ld_req c0; reset_n=0 in c2 -> c3 ld_busy=0, mem_rd_en=0, wr_en=0; no write in c4 despite memory data being driven.
